sdf_delay_buf: RTL and testbench

Parametrised complex delay line for the FFT butterfly pipeline. It holds `LANES` parallel complex samples per word and delays each accepted word by a run-time selectable number of advances: `DEPTH = N/LANES` or `DEPTH/2`. Unlike a free-running shift register, it advances only on valid input or flush, tracks per-entry validity, and reports fill level. It sits between butterfly stages to realign the data streams for the next stage.

---
 rtl/sdf_delay_buf_if.sv | 32 +++
 rtl/sdf_delay_buf.sv | 99 +++++++++
 tb/tb_sdf_delay_buf.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sdf_delay_buf_if.sv
// Handshake and data bundle for the SDF delay line. The producer (master) drives the input word
// and the control bits; the delay line (slave) returns the delayed word and its status.
interface sdf_delay_buf_if #(
    parameter int N     = 256,
    parameter int LANES = 16,
    parameter int WIDTH = 10
);
    localparam int DEPTH = N / LANES;
    localparam int FW    = $clog2(DEPTH + 1);

    logic                    in_valid;
    logic                    flush;
    logic                    cfg_half;
    logic signed [WIDTH-1:0] din_re  [0:LANES-1];
    logic signed [WIDTH-1:0] din_im  [0:LANES-1];

    logic                    out_valid;
    logic signed [WIDTH-1:0] dout_re [0:LANES-1];
    logic signed [WIDTH-1:0] dout_im [0:LANES-1];
    logic [FW-1:0]           fill;
    logic                    half_mode;

    modport master (
        output in_valid, flush, cfg_half, din_re, din_im,
        input  out_valid, dout_re, dout_im, fill, half_mode
    );

    modport slave (
        input  in_valid, flush, cfg_half, din_re, din_im,
        output out_valid, dout_re, dout_im, fill, half_mode
    );
endinterface

// File: rtl/sdf_delay_buf.sv
// Complex delay line for FFT butterfly stages: each accepted word is delayed by DEPTH or DEPTH/2
// advances, where an advance is a valid input or a flush. Tracks per-entry validity and fill level.
module sdf_delay_buf #(
    parameter int N     = 256,
    parameter int LANES = 16,
    parameter int WIDTH = 10
) (
    input  logic           clk,
    input  logic           rst,
    sdf_delay_buf_if.slave bus
);
    localparam int DEPTH = N / LANES;
    localparam int HALF  = DEPTH / 2;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int TW    = $clog2(DEPTH);

    typedef logic signed [WIDTH-1:0] lane_t;

    lane_t            e_re      [0:DEPTH-1][0:LANES-1];
    lane_t            e_im      [0:DEPTH-1][0:LANES-1];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_next;

    lane_t            dout_re_q [0:LANES-1];
    lane_t            dout_im_q [0:LANES-1];
    logic             out_valid_q;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_next;
    logic             half_q;

    logic             adv;
    logic             push;
    logic [TW-1:0]    tail;
    logic             tail_v;

    assign adv    = bus.in_valid | bus.flush;
    assign push   = bus.in_valid & ~bus.flush;
    assign tail   = half_q ? TW'(HALF - 1) : TW'(DEPTH - 1);
    assign tail_v = v[tail];

    // An empty line drops stale valid bits left beyond the active length, so a mode change
    // can never surface words that were parked past the old tail.
    always_comb begin
        v_next = v;
        if (fill_q == '0)
            v_next = '0;
        if (adv)
            v_next = {v_next[DEPTH-2:0], push};
    end

    always_comb begin
        fill_next = fill_q + FW'(push) - FW'(adv & tail_v);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int k = 0; k < LANES; k++) begin
                    e_re[i][k] <= '0;
                    e_im[i][k] <= '0;
                end
            end
            for (int k = 0; k < LANES; k++) begin
                dout_re_q[k] <= '0;
                dout_im_q[k] <= '0;
            end
            v           <= '0;
            out_valid_q <= 1'b0;
            fill_q      <= '0;
            half_q      <= 1'b0;
        end else begin
            if (adv) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    e_re[i] <= e_re[i-1];
                    e_im[i] <= e_im[i-1];
                end
                for (int k = 0; k < LANES; k++) begin
                    e_re[0][k] <= push ? bus.din_re[k] : '0;
                    e_im[0][k] <= push ? bus.din_im[k] : '0;
                end
                dout_re_q   <= e_re[tail];
                dout_im_q   <= e_im[tail];
                out_valid_q <= tail_v;
            end else begin
                out_valid_q <= 1'b0;
            end
            v      <= v_next;
            fill_q <= fill_next;
            if (fill_q == '0)
                half_q <= bus.cfg_half;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout_re   = dout_re_q;
    assign bus.dout_im   = dout_im_q;
    assign bus.fill      = fill_q;
    assign bus.half_mode = half_q;
endmodule

// File: tb/tb_sdf_delay_buf.sv
// Bench for sdf_delay_buf: directed phases plus random traffic, checked every cycle against a
// model that tracks each pending word by the number of advances it still has to wait.
module tb_sdf_delay_buf;
    localparam int N     = 256;
    localparam int LANES = 16;
    localparam int WIDTH = 10;
    localparam int DEPTH = N / LANES;
    localparam int W     = LANES * WIDTH;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        int           cnt;
    } word_t;

    word_t        pend[$];
    logic         clk = 1'b0;
    logic         rst;
    int           checks = 0;
    int           failures = 0;

    logic         mdl_half;
    logic         exp_ov;
    logic [W-1:0] exp_re, exp_im;
    bit           exp_known;
    logic [W-1:0] cur_re, cur_im;

    always #5 clk = ~clk;

    sdf_delay_buf_if #(.N(N), .LANES(LANES), .WIDTH(WIDTH)) bus ();

    sdf_delay_buf #(.N(N), .LANES(LANES), .WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_word(input logic [W-1:0] re, input logic [W-1:0] im);
        cur_re = re;
        cur_im = im;
        for (int k = 0; k < LANES; k++) begin
            bus.din_re[k] = re[k*WIDTH +: WIDTH];
            bus.din_im[k] = im[k*WIDTH +: WIDTH];
        end
    endtask

    task automatic set_pattern(input int w);
        logic [W-1:0] re, im;
        for (int k = 0; k < LANES; k++) begin
            re[k*WIDTH +: WIDTH] = WIDTH'(w * LANES + k);
            im[k*WIDTH +: WIDTH] = WIDTH'(-(w * LANES + k));
        end
        set_word(re, im);
    endtask

    task automatic set_random();
        logic [W-1:0] re, im;
        for (int k = 0; k < LANES; k++) begin
            re[k*WIDTH +: WIDTH] = WIDTH'($urandom);
            im[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        set_word(re, im);
    endtask

    // One clock: apply inputs, advance the model across the edge, compare #1 later.
    task automatic step(input bit iv, input bit fl, input bit ch, input bit r);
        bit           was_empty;
        int           len;
        logic [W-1:0] got_re, got_im;
        rst          = r;
        bus.in_valid = iv;
        bus.flush    = fl;
        bus.cfg_half = ch;
        @(posedge clk);
        if (r) begin
            pend.delete();
            mdl_half  = 1'b0;
            exp_ov    = 1'b0;
            exp_re    = '0;
            exp_im    = '0;
            exp_known = 1'b1;
        end else begin
            was_empty = (pend.size() == 0);
            exp_ov    = 1'b0;
            if (iv || fl) begin
                foreach (pend[i]) pend[i].cnt--;
                if (pend.size() > 0 && pend[0].cnt == 0) begin
                    exp_ov    = 1'b1;
                    exp_re    = pend[0].re;
                    exp_im    = pend[0].im;
                    exp_known = 1'b1;
                    void'(pend.pop_front());
                end else begin
                    exp_known = 1'b0;
                end
            end
            if (was_empty)
                mdl_half = ch;
            len = mdl_half ? DEPTH / 2 : DEPTH;
            if (iv && !fl)
                pend.push_back('{re: cur_re, im: cur_im, cnt: len});
        end
        #1;
        chk("out_valid", W'(bus.out_valid), W'(exp_ov));
        chk("fill", W'(bus.fill), W'(pend.size()));
        chk("half_mode", W'(bus.half_mode), W'(mdl_half));
        if (exp_known) begin
            for (int k = 0; k < LANES; k++) begin
                got_re[k*WIDTH +: WIDTH] = bus.dout_re[k];
                got_im[k*WIDTH +: WIDTH] = bus.dout_im[k];
            end
            chk("dout_re", got_re, exp_re);
            chk("dout_im", got_im, exp_im);
        end
    endtask

    task automatic drain(input int n, input bit ch);
        for (int i = 0; i < n; i++) begin
            set_random();
            step(1'($urandom_range(0, 1)), 1'b1, ch, 1'b0);
        end
    endtask

    initial begin
        set_random();
        mdl_half  = 1'b0;
        exp_known = 1'b0;

        // reset held two cycles
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // continuous stream, counting pattern
        for (int w = 0; w < 40; w++) begin
            set_pattern(w);
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        drain(DEPTH, 1'b0);

        // stalls between every word
        for (int i = 0; i < 40; i++) begin
            set_random();
            step(1'(i % 2 == 0), 1'b0, 1'b0, 1'b0);
        end
        drain(DEPTH, 1'b0);

        // half mode, then a cfg change while partially filled
        for (int i = 0; i < 10; i++) begin
            set_random();
            step(1'b1, 1'b0, 1'b1, 1'b0);
        end
        drain(3, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        drain(5, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // five words then sixteen flushes with in_valid held high
        for (int i = 0; i < 5; i++) begin
            set_random();
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) begin
            set_random();
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end

        // reset in the middle of a stream
        for (int i = 0; i < 9; i++) begin
            set_random();
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        set_random();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            set_random();
            step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        drain(DEPTH, 1'b0);

        // random traffic with occasional mode requests, flushes and resets
        for (int i = 0; i < 500; i++) begin
            set_random();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0));
        end
        drain(DEPTH, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
